// File: rtl/rdata_line_queue.sv
// Read-line queue: buffers 128-bit lines from the read manager and serialises them into
// 32-bit words for the CPU side. Optional sticky overflow flag under `RDQ_OVF_DETECT_EN.
module rdata_line_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] rdat_m_data,
   input  logic         rdat_m_valid,
   input  logic         finish_mrd,
   output logic         rqfull_1,
   output logic         rd_word_valid,
   input  logic         rd_word_ready,
   output logic [31:0]  rd_word_data,
   output logic         rd_word_last,
   output logic         rd_line_done,
   output logic [7:0]   burst_done_cnt
`ifdef RDQ_OVF_DETECT_EN
   ,
   output logic         ovf_err
`endif
);

   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_CNT = CW'(DEPTH - 1);

   logic [127:0]   mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [1:0]     word_sel_q, word_sel_d;
   logic           line_done_q;
   logic [7:0]     burst_cnt_q;

   logic           word_fire;
   logic           pop;
   logic           push_ok;
   logic [3:0][31:0] head_line;

   assign rd_word_valid = (count_q != '0);
   assign word_fire     = rd_word_valid & rd_word_ready;
   assign pop           = word_fire & (word_sel_q == 2'd3);

   // A pop in the same cycle frees the head slot, so a push into a full queue still lands.
   assign push_ok = rdat_m_valid & ((count_q != FULL_CNT) | pop);

   assign head_line    = mem_q[rd_ptr_q];
   assign rd_word_data = rd_word_valid ? head_line[word_sel_q] : 32'd0;
   assign rd_word_last = rd_word_valid & (word_sel_q == 2'd3);
   assign rqfull_1     = (count_q >= AFULL_CNT);
   assign rd_line_done   = line_done_q;
   assign burst_done_cnt = burst_cnt_q;

   // NOTE: every variable driven here gets a default first, so no path can infer a latch.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      word_sel_d = word_sel_q;
      count_d    = count_q;

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end

      if (word_fire) begin
         word_sel_d = word_sel_q + 1'b1;
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
      end

      unique case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         word_sel_q  <= '0;
         line_done_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         word_sel_q  <= word_sel_d;
         line_done_q <= pop;
      end
   end

   // NOTE: the line store is deliberately not reset; count gates every read, so stale data never escapes.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= rdat_m_data;
      end
   end

   // Burst completions are counted independently of the data path and wrap at 8 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         burst_cnt_q <= '0;
      end else if (finish_mrd) begin
         burst_cnt_q <= burst_cnt_q + 8'd1;
      end
   end

`ifdef RDQ_OVF_DETECT_EN
   logic ovf_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_err_q <= 1'b0;
      end else if (rdat_m_valid & ~push_ok) begin
         ovf_err_q <= 1'b1;
      end
   end

   assign ovf_err = ovf_err_q;
`endif

endmodule

// File: tb/tb_rdata_line_queue.sv
// Scoreboard bench for rdata_line_queue: inputs driven 1ns after the rising edge,
// the word stream is checked on the falling edge against a queue of expected words.
`timescale 1ns/1ps
module tb_rdata_line_queue;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } word_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] rdat_m_data;
   logic         rdat_m_valid;
   logic         finish_mrd;
   logic         rqfull_1;
   logic         rd_word_valid;
   logic         rd_word_ready;
   logic [31:0]  rd_word_data;
   logic         rd_word_last;
   logic         rd_line_done;
   logic [7:0]   burst_done_cnt;
`ifdef RDQ_OVF_DETECT_EN
   logic         ovf_err;
`endif

   int    checks = 0;
   int    errors = 0;
   int    fin_cnt = 0;
   bit    accepted;
   word_t sb[$];

   bit          exp_done = 1'b0;
   bit          stall_q  = 1'b0;
   logic [31:0] stall_data = '0;

   rdata_line_queue #(.DEPTH(4), .AW(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rdat_m_data    (rdat_m_data),
      .rdat_m_valid   (rdat_m_valid),
      .finish_mrd     (finish_mrd),
      .rqfull_1       (rqfull_1),
      .rd_word_valid  (rd_word_valid),
      .rd_word_ready  (rd_word_ready),
      .rd_word_data   (rd_word_data),
      .rd_word_last   (rd_word_last),
      .rd_line_done   (rd_line_done),
      .burst_done_cnt (burst_done_cnt)
`ifdef RDQ_OVF_DETECT_EN
      ,
      .ovf_err        (ovf_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of stimulus and predicts acceptance from the scoreboard occupancy:
   // a line is taken if fewer than 4 are held, or if the head's last word pops this cycle.
   task automatic drive(input logic push, input logic [127:0] d, input logic rdy, input logic fin);
      int sz;
      rdat_m_valid  = push;
      rdat_m_data   = d;
      rd_word_ready = rdy;
      finish_mrd    = fin;
      accepted      = 1'b0;
      if (fin) fin_cnt++;
      if (push) begin
         sz = sb.size();
         if (((sz + 3) / 4) < 4 || (rdy && (sz % 4) == 1)) begin
            for (int w = 0; w < 4; w++) sb.push_back('{data: d[32*w +: 32], last: (w == 3)});
            accepted = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Output monitor, half a cycle away from the active edge.
   always @(negedge clk) begin
      word_t e;
      if (!rst_n) begin
         exp_done = 1'b0;
         stall_q  = 1'b0;
      end else begin
         check("line_done", 32'(rd_line_done), 32'(exp_done));
         if (stall_q) begin
            check("stall_valid", 32'(rd_word_valid), 32'd1);
            check("stall_data", rd_word_data, stall_data);
         end
         if (!rd_word_valid) begin
            check("idle_data", rd_word_data, 32'd0);
            check("idle_last", 32'(rd_word_last), 32'd0);
         end
         exp_done = 1'b0;
         if (rd_word_valid && rd_word_ready) begin
            if (sb.size() == 0) begin
               check("spurious_word", 32'(rd_word_valid), 32'd0);
            end else begin
               e = sb.pop_front();
               check("word_data", rd_word_data, e.data);
               check("word_last", 32'(rd_word_last), 32'(e.last));
               exp_done = e.last;
            end
         end
         stall_q    = rd_word_valid & ~rd_word_ready;
         stall_data = rd_word_data;
      end
   end

   initial begin
      logic [127:0] d;
      logic         push, rdy, fin;
      int           lines_done;
      int           cyc;

      rst_n = 1'b0;
      rdat_m_valid = 1'b0;
      rdat_m_data = '0;
      rd_word_ready = 1'b0;
      finish_mrd = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(rd_word_valid), 32'd0);
      check("rst_rqfull", 32'(rqfull_1), 32'd0);
      check("rst_burst", 32'(burst_done_cnt), 32'd0);
      check("rst_line_done", 32'(rd_line_done), 32'd0);
      check("rst_data", rd_word_data, 32'd0);
      check("rst_last", 32'(rd_word_last), 32'd0);
`ifdef RDQ_OVF_DETECT_EN
      check("rst_ovf", 32'(ovf_err), 32'd0);
`endif
      rst_n = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0);
      check("idle_valid", 32'(rd_word_valid), 32'd0);

      // Single line, consumer always ready.
      drive(1'b1, 128'h44444444_33333333_22222222_11111111, 1'b1, 1'b0);
      check("latency_valid", 32'(rd_word_valid), 32'd1);
      check("first_word", rd_word_data, 32'h11111111);
      repeat (4) drive(1'b0, '0, 1'b1, 1'b0);
      check("drained_valid", 32'(rd_word_valid), 32'd0);
      drive(1'b0, '0, 1'b1, 1'b0);

      // Fill with the consumer stalled.
      drive(1'b1, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 1'b0, 1'b0);
      check("cnt1_rqfull", 32'(rqfull_1), 32'd0);
      drive(1'b1, 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, 1'b0, 1'b0);
      check("cnt2_rqfull", 32'(rqfull_1), 32'd0);
      drive(1'b1, 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0, 1'b0, 1'b0);
      check("cnt3_rqfull", 32'(rqfull_1), 32'd1);
      drive(1'b1, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0, 1'b0, 1'b0);
      check("cnt4_rqfull", 32'(rqfull_1), 32'd1);
      drive(1'b1, 128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE, 1'b0, 1'b0);
      check("drop_head", rd_word_data, 32'hA0A0A0A0);
`ifdef RDQ_OVF_DETECT_EN
      check("ovf_set", 32'(ovf_err), 32'd1);
`endif
      repeat (2) drive(1'b0, '0, 1'b0, 1'b0);
`ifdef RDQ_OVF_DETECT_EN
      check("ovf_sticky", 32'(ovf_err), 32'd1);
`endif

      // Full queue: pop of the head's last word and a push in the same cycle.
      repeat (3) drive(1'b0, '0, 1'b1, 1'b0);
      check("sel3_last", 32'(rd_word_last), 32'd1);
      drive(1'b1, 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0, 1'b1, 1'b0);
      check("swap_rqfull", 32'(rqfull_1), 32'd1);
      check("swap_head", rd_word_data, 32'hB0B0B0B0);
      drive(1'b1, 128'h99999999_99999999_99999999_99999999, 1'b0, 1'b0);
      repeat (17) drive(1'b0, '0, 1'b1, 1'b0);
      check("swap_drained", sb.size(), 32'd0);
      check("swap_valid", 32'(rd_word_valid), 32'd0);

      // Random ready stalls over 20 lines with burst-done pulses.
      lines_done = 0;
      cyc = 0;
      while (!(lines_done == 20 && fin_cnt == 258 && sb.size() == 0)) begin
         if (cyc >= 5000) begin
            check("random_timeout_lines", lines_done, 32'd20);
            check("random_timeout_sb", sb.size(), 32'd0);
            break;
         end
         push = (lines_done < 20) && ($urandom_range(0, 2) != 0);
         d    = {$urandom(), $urandom(), $urandom(), $urandom()};
         fin  = (fin_cnt < 258) && ($urandom_range(0, 1) == 1);
         rdy  = ($urandom_range(0, 3) != 0);
         drive(push, d, rdy, fin);
         if (push && accepted) lines_done++;
         cyc++;
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      check("burst_cnt_wrap", 32'(burst_done_cnt), 32'd2);
      check("random_valid", 32'(rd_word_valid), 32'd0);

      // Reset in the middle of a partially consumed line.
      drive(1'b1, 128'h77777777_66666666_55555555_54545454, 1'b1, 1'b0);
      repeat (2) drive(1'b0, '0, 1'b1, 1'b0);
      rst_n = 1'b0;
      sb.delete();
      #2;
      check("midrst_valid", 32'(rd_word_valid), 32'd0);
      check("midrst_data", rd_word_data, 32'd0);
      check("midrst_burst", 32'(burst_done_cnt), 32'd0);
`ifdef RDQ_OVF_DETECT_EN
      check("midrst_ovf", 32'(ovf_err), 32'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) drive(1'b0, '0, 1'b1, 1'b0);
      check("post_rst_valid", 32'(rd_word_valid), 32'd0);
      check("post_rst_rqfull", 32'(rqfull_1), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
